// File: rtl/alu_feeder_pkg.sv
// Shared opcode codes, command record layout and FIFO sizing for the ALU feeder.
package alu_feeder_pkg;

   localparam logic [2:0] sOP_NULL    = 3'b000;
   localparam logic [2:0] sOP_ADD     = 3'b001;
   localparam logic [2:0] sOP_SUB     = 3'b010;
   localparam logic [2:0] sOP_AND     = 3'b011;
   localparam logic [2:0] sOP_OR      = 3'b100;
   localparam logic [2:0] sOP_XOR     = 3'b101;
   localparam logic [2:0] sOP_PASSB   = 3'b110;
   localparam logic [2:0] sOP_ILLEGAL = 3'b111;

   localparam int CMD_W      = 12;
   localparam int FIFO_DEPTH = 4;

   // Field order matches the FIFO entry layout {load, op, operand}.
   typedef struct packed {
      logic       load;
      logic [2:0] op;
      logic [7:0] operand;
   } cmd_t;

   function automatic logic op_is_illegal(input logic [2:0] op);
      return op == sOP_ILLEGAL;
   endfunction

endpackage

// File: rtl/alu_feeder_cmd_fifo.sv
// Command FIFO: registered occupancy count, power-of-two depth so pointers wrap naturally.
module cmd_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                     in_clk,
   input  logic                     in_rst,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             not_full;
   logic             do_push;
   logic             do_pop;

   // Readiness looks only at the registered count, so a full FIFO refuses a push even
   // in a cycle where it is also popped. Reset forces ready high while blocking pushes.
   assign not_full   = count_q < FULL_CNT;
   assign push_ready = in_rst | not_full;
   assign do_push    = push_valid & not_full & ~in_rst;
   assign do_pop     = pop & (count_q != '0) & ~in_rst;

   assign head_data = mem_q[rd_ptr_q];
   assign empty     = count_q == '0;
   assign count     = count_q;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Entry storage carries no reset; only entries below the count are ever read.
   always_ff @(posedge in_clk) begin
      mem_q <= mem_d;
   end

   // Pointer and count registers with synchronous reset.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/alu_feeder.sv
// ALU feeder: queues commands, issues them to an external combinational ALU and
// writes the result (or a direct load value) back into the accumulator.
//
// state  | meaning
// IDLE   | waiting for a queued command; pops head and registers ALU operands
// EXEC   | ALU settles on registered operands; result captured at end of cycle
// WB     | accumulator/carry write-back, done/err pulse issued, back to IDLE
module alu_feeder
   import alu_feeder_pkg::*;
(
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic       in_valid,
   input  logic       in_load,
   input  logic [2:0] in_op,
   input  logic [7:0] in_operand,
   output logic       out_ready,
   output logic [7:0] out_alu_a,
   output logic [7:0] out_alu_b,
   output logic [2:0] out_alu_op,
   input  logic [8:0] in_alu_result,
   output logic [7:0] out_acc,
   output logic       out_carry,
   output logic       out_zero,
   output logic       out_done,
   output logic       out_err,
   output logic       out_busy,
   output logic [2:0] out_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;

   logic [1:0] state_q, state_d;
   logic [7:0] acc_q, acc_d;
   logic       carry_q, carry_d;
   logic [7:0] alu_a_q, alu_a_d;
   logic [7:0] alu_b_q, alu_b_d;
   logic [2:0] alu_op_q, alu_op_d;
   logic       load_q, load_d;
   logic       err_flag_q, err_flag_d;
   logic [8:0] res_q, res_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   cmd_t       push_cmd;
   cmd_t       head_cmd;
   logic       fifo_pop;
   logic       fifo_empty;

   assign push_cmd = {in_load, in_op, in_operand};

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .in_clk     (in_clk),
      .in_rst     (in_rst),
      .push_valid (in_valid),
      .push_ready (out_ready),
      .push_data  (push_cmd),
      .pop        (fifo_pop),
      .head_data  (head_cmd),
      .empty      (fifo_empty),
      .count      (out_count)
   );

   // Sequencer: issue on pop, capture ALU result in EXEC, write back in WB.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      carry_d    = carry_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      load_d     = load_q;
      err_flag_d = err_flag_q;
      res_d      = res_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      fifo_pop   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               alu_a_d    = acc_q;
               alu_b_d    = head_cmd.operand;
               load_d     = head_cmd.load;
               err_flag_d = op_is_illegal(head_cmd.op);
               alu_op_d   = op_is_illegal(head_cmd.op) ? sOP_NULL : head_cmd.op;
               state_d    = S_EXEC;
            end
         end
         S_EXEC: begin
            res_d   = in_alu_result;
            state_d = S_WB;
         end
         S_WB: begin
            // A load always writes; an illegal ALU op leaves acc and carry untouched.
            if (load_q) begin
               acc_d   = alu_b_q;
               carry_d = 1'b0;
            end else if (!err_flag_q) begin
               acc_d   = res_q[7:0];
               carry_d = res_q[8];
            end
            done_d  = 1'b1;
            err_d   = err_flag_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any command in flight.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         carry_q    <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= sOP_NULL;
         load_q     <= 1'b0;
         err_flag_q <= 1'b0;
         res_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         carry_q    <= carry_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         load_q     <= load_d;
         err_flag_q <= err_flag_d;
         res_q      <= res_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign out_alu_a  = alu_a_q;
   assign out_alu_b  = alu_b_q;
   assign out_alu_op = alu_op_q;
   assign out_acc    = acc_q;
   assign out_carry  = carry_q;
   assign out_zero   = acc_q == 8'h00;
   assign out_done   = done_q;
   assign out_err    = err_q;
   assign out_busy   = state_q != S_IDLE;

endmodule

// File: tb/tb_alu_feeder.sv
// Directed bench for alu_feeder with a small behavioural ALU on the side.
module tb_alu_feeder;
   import alu_feeder_pkg::*;

   logic       in_clk = 1'b0;
   logic       in_rst;
   logic       in_valid;
   logic       in_load;
   logic [2:0] in_op;
   logic [7:0] in_operand;
   logic       out_ready;
   logic [7:0] out_alu_a;
   logic [7:0] out_alu_b;
   logic [2:0] out_alu_op;
   logic [8:0] in_alu_result;
   logic [7:0] out_acc;
   logic       out_carry;
   logic       out_zero;
   logic       out_done;
   logic       out_err;
   logic       out_busy;
   logic [2:0] out_count;

   int n_chk = 0;
   int n_err = 0;

   alu_feeder dut (
      .in_clk        (in_clk),
      .in_rst        (in_rst),
      .in_valid      (in_valid),
      .in_load       (in_load),
      .in_op         (in_op),
      .in_operand    (in_operand),
      .out_ready     (out_ready),
      .out_alu_a     (out_alu_a),
      .out_alu_b     (out_alu_b),
      .out_alu_op    (out_alu_op),
      .in_alu_result (in_alu_result),
      .out_acc       (out_acc),
      .out_carry     (out_carry),
      .out_zero      (out_zero),
      .out_done      (out_done),
      .out_err       (out_err),
      .out_busy      (out_busy),
      .out_count     (out_count)
   );

   always #5 in_clk = ~in_clk;

   // External ALU model; bit 8 is carry for ADD and borrow for SUB.
   always_comb begin
      in_alu_result = 9'h000;
      case (out_alu_op)
         sOP_NULL:  in_alu_result = {1'b0, out_alu_a};
         sOP_ADD:   in_alu_result = {1'b0, out_alu_a} + {1'b0, out_alu_b};
         sOP_SUB:   in_alu_result = {1'b0, out_alu_a} - {1'b0, out_alu_b};
         sOP_AND:   in_alu_result = {1'b0, out_alu_a & out_alu_b};
         sOP_OR:    in_alu_result = {1'b0, out_alu_a | out_alu_b};
         sOP_XOR:   in_alu_result = {1'b0, out_alu_a ^ out_alu_b};
         sOP_PASSB: in_alu_result = {1'b0, out_alu_b};
         default:   in_alu_result = 9'h000;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       ld;
      logic [2:0] op;
      logic [7:0] opd;
      logic [7:0] acc;
      logic       c;
      logic       z;
      logic       e;
   } vec_t;

   vec_t vecs[13];

   // Retirement monitor for the streaming sequence.
   logic       mon_en = 1'b0;
   int         ret_idx = 0;
   logic [7:0] exp_ret[6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};

   always @(negedge in_clk) begin
      if (mon_en && out_done) begin
         if (ret_idx < 6) chk($sformatf("stream_ret%0d_acc", ret_idx), 32'(out_acc), 32'(exp_ret[ret_idx]));
         else             chk("stream_extra_retire", 32'(ret_idx), 32'd5);
         ret_idx++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive_cmd(input logic ld, input logic [2:0] op, input logic [7:0] opd);
      in_valid   = 1'b1;
      in_load    = ld;
      in_op      = op;
      in_operand = opd;
   endtask

   // Push one command and follow it edge by edge through retirement.
   task automatic run_one(input vec_t v, input logic [7:0] prev_acc, input int idx);
      logic [2:0] exp_op;
      exp_op = (v.op == sOP_ILLEGAL) ? sOP_NULL : v.op;
      @(negedge in_clk);
      drive_cmd(v.ld, v.op, v.opd);
      @(posedge in_clk);
      #1 in_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge in_clk);
         #1;
         chk($sformatf("v%0d_done_e%0d", idx, k), 32'(out_done), (k == 3) ? 32'd1 : 32'd0);
         if (k == 1) begin
            chk($sformatf("v%0d_alu_op", idx), 32'(out_alu_op), 32'(exp_op));
            chk($sformatf("v%0d_alu_a", idx), 32'(out_alu_a), 32'(prev_acc));
            chk($sformatf("v%0d_alu_b", idx), 32'(out_alu_b), 32'(v.opd));
            chk($sformatf("v%0d_busy", idx), 32'(out_busy), 32'd1);
         end
         if (k == 3) begin
            chk($sformatf("v%0d_err", idx), 32'(out_err), 32'(v.e));
            chk($sformatf("v%0d_acc", idx), 32'(out_acc), 32'(v.acc));
            chk($sformatf("v%0d_carry", idx), 32'(out_carry), 32'(v.c));
            chk($sformatf("v%0d_zero", idx), 32'(out_zero), 32'(v.z));
         end
      end
   endtask

   initial begin
      logic [7:0] prev;
      int         cnt_exp[8];
      logic       seen_done;

      vecs[0]  = '{1'b1, sOP_NULL,    8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, sOP_ADD,     8'h10, 8'h15, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, sOP_ADD,     8'hF0, 8'h05, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, sOP_SUB,     8'h06, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, sOP_ILLEGAL, 8'h33, 8'hFF, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, sOP_AND,     8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, sOP_OR,      8'hA0, 8'hAF, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, sOP_XOR,     8'hAF, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, sOP_NULL,    8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, sOP_SUB,     8'hF0, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, sOP_NULL,    8'h12, 8'h12, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, sOP_PASSB,   8'h7E, 8'h7E, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, sOP_ADD,     8'h01, 8'h7F, 1'b0, 1'b0, 1'b0};

      // Reset with a command held on the inputs: nothing may be queued.
      in_rst = 1'b1;
      drive_cmd(1'b1, sOP_NULL, 8'hAA);
      #1 chk("rst_ready", 32'(out_ready), 32'd1);
      repeat (2) @(posedge in_clk);
      @(negedge in_clk);
      in_rst   = 1'b0;
      in_valid = 1'b0;
      chk("rst_count",  32'(out_count),  32'd0);
      chk("rst_acc",    32'(out_acc),    32'd0);
      chk("rst_alu_a",  32'(out_alu_a),  32'd0);
      chk("rst_alu_b",  32'(out_alu_b),  32'd0);
      chk("rst_alu_op", 32'(out_alu_op), 32'(sOP_NULL));
      chk("rst_carry",  32'(out_carry),  32'd0);
      chk("rst_zero",   32'(out_zero),   32'd1);
      chk("rst_done",   32'(out_done),   32'd0);
      chk("rst_err",    32'(out_err),    32'd0);
      chk("rst_busy",   32'(out_busy),   32'd0);

      // Single commands, one at a time.
      prev = 8'h00;
      for (int i = 0; i < 13; i++) begin
         run_one(vecs[i], prev, i);
         prev = vecs[i].acc;
      end

      // Back-to-back pushes: fills, refuses two (one during a pop), wraps pointers.
      cnt_exp = '{1, 1, 2, 3, 3, 4, 4, 3};
      mon_en  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] opd;
         opd = 8'h01 << i;
         @(negedge in_clk);
         drive_cmd(i == 0, (i == 0) ? sOP_NULL : sOP_ADD, opd);
         @(posedge in_clk);
         #1;
         chk($sformatf("stream_count_e%0d", i), 32'(out_count), 32'(cnt_exp[i]));
         chk($sformatf("stream_ready_e%0d", i), 32'(out_ready), (cnt_exp[i] < 4) ? 32'd1 : 32'd0);
      end
      @(negedge in_clk);
      in_valid = 1'b0;
      for (int n = 0; n < 100 && ret_idx < 6; n++) @(posedge in_clk);
      repeat (10) @(posedge in_clk);
      #1;
      chk("stream_retired", 32'(ret_idx), 32'd6);
      chk("stream_final_acc", 32'(out_acc), 32'h3F);
      chk("stream_final_count", 32'(out_count), 32'd0);
      mon_en = 1'b0;

      // Reset while a command is in EXEC with two more queued.
      for (int i = 0; i < 4; i++) begin
         @(negedge in_clk);
         drive_cmd(i == 0, (i == 0) ? sOP_NULL : sOP_ADD, (i == 0) ? 8'h77 : 8'(i));
         @(posedge in_clk);
      end
      @(negedge in_clk);
      in_valid = 1'b0;
      @(posedge in_clk);
      #1;
      chk("abort_pre_busy",  32'(out_busy),  32'd1);
      chk("abort_pre_count", 32'(out_count), 32'd2);
      chk("abort_pre_acc",   32'(out_acc),   32'h77);
      in_rst = 1'b1;
      @(posedge in_clk);
      #1;
      chk("abort_done",  32'(out_done),  32'd0);
      chk("abort_count", 32'(out_count), 32'd0);
      chk("abort_acc",   32'(out_acc),   32'd0);
      chk("abort_busy",  32'(out_busy),  32'd0);
      @(negedge in_clk);
      in_rst    = 1'b0;
      seen_done = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge in_clk);
         if (out_done) seen_done = 1'b1;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);

      // Fill the FIFO, then reset with in_valid still high.
      for (int i = 0; i < 6; i++) begin
         @(negedge in_clk);
         drive_cmd(1'b0, sOP_ADD, 8'h01);
         @(posedge in_clk);
      end
      #1;
      chk("full_count", 32'(out_count), 32'd4);
      chk("full_ready", 32'(out_ready), 32'd0);
      in_rst = 1'b1;
      #1 chk("full_rst_ready", 32'(out_ready), 32'd1);
      @(posedge in_clk);
      #1 chk("full_rst_count_e1", 32'(out_count), 32'd0);
      @(posedge in_clk);
      #1 chk("full_rst_count_e2", 32'(out_count), 32'd0);
      @(negedge in_clk);
      in_rst   = 1'b0;
      in_valid = 1'b0;
      @(posedge in_clk);
      #1;
      chk("post_rst_count", 32'(out_count), 32'd0);
      chk("post_rst_busy",  32'(out_busy),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
